// File: rtl/fifo_arb_pkg.sv
// Shared constants and state type for the fifo write-side arbiter.
// Also used by the matching read-side arbiter.
package fifo_arb_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   localparam int NREQ_DEF  = 4;
   localparam int DW_DEF    = 8;
   localparam int BURST_DEF = 4;

   typedef enum logic {
      S_IDLE  = ST_IDLE,
      S_GRANT = ST_GRANT
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or above i_ptr, with wrap.
// Purely combinational.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_pick,
   output logic            o_valid
);

   logic [2*NREQ-1:0] w_dbl;
   logic [2*NREQ-1:0] w_back;
   logic [NREQ-1:0]   w_rot;
   logic [NREQ-1:0]   w_first;

   // Rotate so i_ptr lands on bit 0, isolate lowest set bit, rotate back.
   assign w_dbl   = {i_req, i_req} >> i_ptr;
   assign w_rot   = w_dbl[NREQ-1:0];
   assign w_first = w_rot & (~w_rot + NREQ'(1));
   assign w_back  = {w_first, w_first} << i_ptr;

   assign o_pick  = w_back[2*NREQ-1:NREQ];
   assign o_valid = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NREQ producers.
// Each grant lasts until packet end, BURST words, or the owner drops req.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int DW    = DW_DEF,
   parameter int BURST = BURST_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NREQ-1:0]    i_req,
   input  logic [NREQ*DW-1:0] i_req_data,
   input  logic [NREQ-1:0]    i_req_last,
   input  logic               i_fifo_full,
   output logic               o_fifo_we,
   output logic [DW-1:0]      o_fifo_din,
   output logic [NREQ-1:0]    o_grant,
   output logic [NREQ-1:0]    o_ack,
   output logic               o_busy
);

   localparam int PW = $clog2(NREQ);
   localparam int BW = $clog2(BURST + 1);

   arb_state_t        r_state;
   logic [NREQ-1:0]   r_grant;
   logic [PW-1:0]     r_rr_ptr;
   logic [BW-1:0]     r_beat_cnt;

   logic [NREQ-1:0]   w_pick;
   logic              w_valid;
   logic              w_in_grant;
   logic              w_req_g;
   logic              w_last_g;
   logic              w_beat;
   logic              w_cap;
   logic              w_release;
   logic [PW-1:0]     w_gidx;
   logic [PW-1:0]     w_next_ptr;
   logic [DW-1:0]     w_din;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .i_req   (i_req),
      .i_ptr   (r_rr_ptr),
      .o_pick  (w_pick),
      .o_valid (w_valid)
   );

   // r_grant is all-zero in IDLE, so the mux below yields 0 there.
   always_comb begin
      w_gidx = '0;
      w_din  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_grant[i]) begin
            w_gidx = PW'(i);
            w_din  = w_din | i_req_data[i*DW +: DW];
         end
      end
   end

   assign w_in_grant = (r_state == S_GRANT);
   assign w_req_g    = |(i_req & r_grant);
   assign w_last_g   = |(i_req_last & r_grant);
   assign w_beat     = w_in_grant & w_req_g & ~i_fifo_full;
   assign w_cap      = (r_beat_cnt == BW'(BURST - 1));
   assign w_release  = w_in_grant &
                       (~w_req_g | (w_beat & (w_last_g | w_cap)));
   assign w_next_ptr = (w_gidx == PW'(NREQ - 1)) ?
                       '0 : w_gidx + PW'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  r_grant    <= w_pick;
                  r_beat_cnt <= '0;
                  r_state    <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (w_beat) begin
                  r_beat_cnt <= r_beat_cnt + BW'(1);
               end
               if (w_release) begin
                  r_state  <= S_IDLE;
                  r_grant  <= '0;
                  r_rr_ptr <= w_next_ptr;
               end
            end
         endcase
      end
   end

   assign o_fifo_we  = w_beat;
   assign o_fifo_din = w_din;
   assign o_grant    = r_grant;
   assign o_ack      = r_grant & {NREQ{w_beat}};
   assign o_busy     = w_in_grant;

endmodule
